// File: rtl/lockin_demod_acc.sv
// lockin_demod_acc: dual-phase lock-in demodulator with per-measurement X/Y accumulation.
// Optional feature macro: LOCKIN_SATURATE_EN (saturating accumulators + sticky overflow flag).
module lockin_demod_acc #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned REF_W  = 16,
  parameter int unsigned ACC_W  = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     start,
  input  logic [31:0]              n_muestras,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     data_valid,
  input  logic signed [REF_W-1:0]  ref_sin,
  input  logic signed [REF_W-1:0]  ref_cos,
  output logic signed [ACC_W-1:0]  out_x,
  output logic signed [ACC_W-1:0]  out_y,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overflow
);

  localparam int unsigned XW = DATA_W + 1;
  localparam int unsigned PW = DATA_W + REF_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state, next_state;
  logic [31:0]               n_lat, cnt;
  logic                      v1, v2;
  logic signed [XW-1:0]      x1;
  logic signed [REF_W-1:0]   s1, c1;
  logic signed [PW-1:0]      p_s, p_c;
  logic signed [ACC_W-1:0]   acc_x, acc_y;
  logic signed [ACC_W-1:0]   nxt_x_c, nxt_y_c;
  logic signed [XW-1:0]      x_c;
  logic                      start_ok_c, accept_c, last_c;
`ifdef LOCKIN_SATURATE_EN
  logic                      ovf_x_c, ovf_y_c;
`endif

  // Offset binary to signed: flip the MSB and sign-extend by one bit.
  assign x_c = {~data_in[DATA_W-1], ~data_in[DATA_W-1], data_in[DATA_W-2:0]};

  // Accept conditions for a new measurement and for an incoming sample.
  always_comb begin
    start_ok_c = enable && (state == IDLE) && start && (n_muestras != 32'd0);
    accept_c   = enable && (state == RUN) && data_valid;
    last_c     = accept_c && ((cnt + 32'd1) == n_lat);
  end

  // Accumulate step: sign-extend product, add, optionally clamp on signed overflow.
  always_comb begin
    logic signed [ACC_W-1:0] ext_x, ext_y, sum_x, sum_y;
    ext_x   = ACC_W'(p_s);
    ext_y   = ACC_W'(p_c);
    sum_x   = acc_x + ext_x;
    sum_y   = acc_y + ext_y;
    nxt_x_c = sum_x;
    nxt_y_c = sum_y;
`ifdef LOCKIN_SATURATE_EN
    ovf_x_c = (acc_x[ACC_W-1] == ext_x[ACC_W-1]) && (sum_x[ACC_W-1] != acc_x[ACC_W-1]);
    ovf_y_c = (acc_y[ACC_W-1] == ext_y[ACC_W-1]) && (sum_y[ACC_W-1] != acc_y[ACC_W-1]);
    if (ovf_x_c) nxt_x_c = acc_x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    if (ovf_y_c) nxt_y_c = acc_y[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic; everything freezes while enable is low.
  always_comb begin
    next_state = state;
    if (enable) begin
      case (state)
        IDLE:    if (start_ok_c) next_state = RUN;
        RUN:     if (last_c) next_state = DRAIN;
        DRAIN:   if (!v1 && !v2) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Three-stage multiply/accumulate pipeline, sample counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_lat     <= '0;
      cnt       <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      x1        <= '0;
      s1        <= '0;
      c1        <= '0;
      p_s       <= '0;
      p_c       <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef LOCKIN_SATURATE_EN
      overflow  <= 1'b0;
`endif
    end else if (enable) begin
      out_valid <= (state == DONE);
      busy      <= (next_state != IDLE);
      if (state == DONE) begin
        out_x <= acc_x;
        out_y <= acc_y;
      end
      if (start_ok_c) begin
        n_lat    <= n_muestras;
        cnt      <= '0;
        v1       <= 1'b0;
        v2       <= 1'b0;
        acc_x    <= '0;
        acc_y    <= '0;
`ifdef LOCKIN_SATURATE_EN
        overflow <= 1'b0;
`endif
      end else begin
        v1 <= accept_c;
        if (accept_c) begin
          x1  <= x_c;
          s1  <= ref_sin;
          c1  <= ref_cos;
          cnt <= cnt + 32'd1;
        end
        v2 <= v1;
        if (v1) begin
          p_s <= PW'(x1) * PW'(s1);
          p_c <= PW'(x1) * PW'(c1);
        end
        if (v2) begin
          acc_x <= nxt_x_c;
          acc_y <= nxt_y_c;
`ifdef LOCKIN_SATURATE_EN
          overflow <= overflow | ovf_x_c | ovf_y_c;
`endif
        end
      end
    end
  end

`ifndef LOCKIN_SATURATE_EN
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_lockin_demod_acc.sv
// Directed bench for lockin_demod_acc: a 64-bit default instance and a 32-bit
// instance for the accumulator-overflow case, both driven by the same stimulus.
module tb_lockin_demod_acc;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               start;
  logic [31:0]        n_muestras;
  logic [13:0]        data_in;
  logic               data_valid;
  logic signed [15:0] ref_sin, ref_cos;

  logic signed [63:0] out_x, out_y;
  logic               out_valid, busy, overflow;
  logic signed [31:0] out_x32, out_y32;
  logic               out_valid32, busy32, overflow32;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lockin_demod_acc dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
    .n_muestras(n_muestras), .data_in(data_in), .data_valid(data_valid),
    .ref_sin(ref_sin), .ref_cos(ref_cos), .out_x(out_x), .out_y(out_y),
    .out_valid(out_valid), .busy(busy), .overflow(overflow)
  );

  lockin_demod_acc #(.ACC_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
    .n_muestras(n_muestras), .data_in(data_in), .data_valid(data_valid),
    .ref_sin(ref_sin), .ref_cos(ref_cos), .out_x(out_x32), .out_y(out_y32),
    .out_valid(out_valid32), .busy(busy32), .overflow(overflow32)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One measurement: optional gaps, an optional enable pause and an optional stray start.
  task automatic run_meas(input int n, input logic [13:0] din, input logic signed [15:0] s,
                          input logic signed [15:0] c, input bit gap, input int pause_after,
                          input int pause_len, input int stray_at,
                          output int start_edge, output int last_edge, output int ov_edge,
                          output bit busy_ok, output bit got_ov);
    int k;
    busy_ok = 1'b1;
    enable = 1'b1;
    start = 1'b1;
    n_muestras = 32'(n);
    step();
    start = 1'b0;
    start_edge = cyc;
    data_in = din;
    ref_sin = s;
    ref_cos = c;
    k = 0;
    while (k < n) begin
      if (pause_len > 0 && k == pause_after) begin
        enable = 1'b0;
        data_valid = 1'b1;
        repeat (pause_len) begin
          step();
          busy_ok &= busy;
        end
        enable = 1'b1;
      end
      data_valid = 1'b1;
      if (k == stray_at) begin
        start = 1'b1;
        n_muestras = 32'd2;
      end
      step();
      start = 1'b0;
      n_muestras = 32'(n);
      last_edge = cyc;
      busy_ok &= busy;
      k++;
      if (gap) begin
        data_valid = 1'b0;
        step();
        busy_ok &= busy;
      end
    end
    data_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      busy_ok &= busy;
      step();
    end
    got_ov = out_valid;
    ov_edge = cyc;
  endtask

  initial begin
    int se, le, oe;
    bit bok, gov;

    reset_n = 1'b0;
    enable = 1'b0;
    start = 1'b0;
    n_muestras = '0;
    data_in = '0;
    data_valid = 1'b0;
    ref_sin = '0;
    ref_cos = '0;
    repeat (3) step();

    chk("rst_out_x", out_x, 64'sd0);
    chk("rst_out_y", out_y, 64'sd0);
    chk("rst_out_valid", 64'(out_valid), 64'sd0);
    chk("rst_busy", 64'(busy), 64'sd0);
    chk("rst_overflow", 64'(overflow), 64'sd0);

    reset_n = 1'b1;
    enable = 1'b1;
    step();

    // DC sum, continuous stream.
    run_meas(8, 14'd8292, 16'sd1000, 16'sd0, 1'b0, -1, 0, -1, se, le, oe, bok, gov);
    chk("dc_out_valid_seen", 64'(gov), 64'sd1);
    chk("dc_latency", 64'(oe - le), 64'sd4);
    chk("dc_out_x", out_x, 64'sd800000);
    chk("dc_out_y", out_y, 64'sd0);
    chk("dc_out_x32", out_x32, 64'sd800000);
    chk("dc_busy_during", 64'(bok), 64'sd1);
    chk("dc_busy_fall", 64'(busy), 64'sd0);
    step();
    chk("dc_out_valid_pulse", 64'(out_valid), 64'sd0);
    chk("dc_out_x_hold", out_x, 64'sd800000);

    // Gapped stream.
    run_meas(8, 14'd8292, 16'sd1000, 16'sd0, 1'b1, -1, 0, -1, se, le, oe, bok, gov);
    chk("gap_out_valid_seen", 64'(gov), 64'sd1);
    chk("gap_out_x", out_x, 64'sd800000);
    chk("gap_out_y", out_y, 64'sd0);
    chk("gap_busy_during", 64'(bok), 64'sd1);
    step();

    // Enable pause of 5 cycles after 4 samples.
    run_meas(8, 14'd8292, 16'sd1000, 16'sd0, 1'b0, 4, 5, -1, se, le, oe, bok, gov);
    chk("pause_out_valid_seen", 64'(gov), 64'sd1);
    chk("pause_total_latency", 64'(oe - se), 64'sd17);
    chk("pause_out_x", out_x, 64'sd800000);
    step();

    // Mixed signs: x=-37, sin=-1234, cos=555, 5 samples.
    run_meas(5, 14'd8155, -16'sd1234, 16'sd555, 1'b0, -1, 0, -1, se, le, oe, bok, gov);
    chk("mix_out_x", out_x, 64'sd228290);
    chk("mix_out_y", out_y, -64'sd102675);
    step();

    // Stray start during RUN is ignored; count ends at the original n.
    run_meas(8, 14'd8292, 16'sd1000, 16'sd0, 1'b0, -1, 0, 2, se, le, oe, bok, gov);
    chk("stray_latency", 64'(oe - se), 64'sd12);
    chk("stray_out_x", out_x, 64'sd800000);
    step();

    // Start with n_muestras=0 is ignored.
    start = 1'b1;
    n_muestras = 32'd0;
    step();
    start = 1'b0;
    step();
    chk("zero_n_busy", 64'(busy), 64'sd0);

    // Reset after 3 of 8 samples.
    start = 1'b1;
    n_muestras = 32'd8;
    step();
    start = 1'b0;
    data_in = 14'd8292;
    ref_sin = 16'sd1000;
    data_valid = 1'b1;
    repeat (3) step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_x", out_x, 64'sd0);
    chk("midrst_busy", 64'(busy), 64'sd0);
    data_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    run_meas(4, 14'd0, 16'sd3, -16'sd2, 1'b0, -1, 0, -1, se, le, oe, bok, gov);
    chk("postrst_out_y", out_y, 64'sd65536);
    chk("postrst_out_x", out_x, -64'sd98304);
    step();

    // Overflow case on the 32-bit instance: 10 * 8191 * 32767 = 2683944970.
    run_meas(10, 14'd16383, 16'sd32767, 16'sd0, 1'b0, -1, 0, -1, se, le, oe, bok, gov);
    chk("ovf_out_x64", out_x, 64'sd2683944970);
`ifdef LOCKIN_SATURATE_EN
    chk("ovf_out_x32", out_x32, 64'sd2147483647);
    chk("ovf_flag32", 64'(overflow32), 64'sd1);
`else
    chk("ovf_out_x32", out_x32, -64'sd1611022326);
    chk("ovf_flag32", 64'(overflow32), 64'sd0);
`endif
    chk("ovf_flag64", 64'(overflow), 64'sd0);
    step();

    // Next accepted start clears overflow.
    run_meas(8, 14'd8292, 16'sd1000, 16'sd0, 1'b0, -1, 0, -1, se, le, oe, bok, gov);
    chk("ovf_cleared32", 64'(overflow32), 64'sd0);
    chk("after_ovf_out_x32", out_x32, 64'sd800000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
